// File: rtl/data_memory_responder_if.sv
// Purpose : CPU <-> data memory request/response bundle.
// Signals : MemRead/MemWrite/Address/WriteData  (CPU -> memory request, held until ready)
//           ReadData/ready/err                  (memory -> CPU, valid only while ready=1)
//           busy                                (memory -> CPU stall request)
interface data_memory_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, ready, busy, err
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, ready, busy, err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Purpose : Word-addressed data memory with a fixed number of wait states per
//           access, a one-cycle ready pulse and an access-fault flag.
// Ports   : clock - single rising-edge clock
//           reset - synchronous active-high reset (memory contents preserved)
//           bus   - data_memory_responder_if.slave (request in, response/stall out)
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               rd_q;
  logic               wr_q;
  logic               ready_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               req_c;
  logic [31:0]        acc_addr_c;
  logic [31:0]        acc_wdata_c;
  logic               acc_rd_c;
  logic               acc_wr_c;
  logic [29:0]        idx_c;
  logic               fault_c;
  logic               enter_resp_c;
  logic               do_write_c;
  logic [31:0]        rdata_d;

  // Access attributes come straight from the bus in IDLE (needed when there
  // are no wait states) and from the latched copy once the access is underway.
  always_comb begin
    req_c        = bus.MemRead | bus.MemWrite;
    acc_addr_c   = addr_q;
    acc_wdata_c  = wdata_q;
    acc_rd_c     = rd_q;
    acc_wr_c     = wr_q;
    if (state_q == S_IDLE) begin
      acc_addr_c  = bus.Address;
      acc_wdata_c = bus.WriteData;
      acc_rd_c    = bus.MemRead;
      acc_wr_c    = bus.MemWrite;
    end
    idx_c   = acc_addr_c[31:2];
    fault_c = (acc_addr_c[1:0] != 2'b00)
            | ({2'b00, idx_c} >= 32'(DEPTH_WORDS))
            | (acc_rd_c & acc_wr_c);

    // The edge that enters RESP is the one that commits the access.
    enter_resp_c = ~reset &
                   (((state_q == S_IDLE) & req_c & (WAIT_CYCLES == 0)) |
                    ((state_q == S_WAIT) & (cnt_q == CNT_W'(1))));
    do_write_c   = enter_resp_c & acc_wr_c & ~fault_c;

    rdata_d = 32'h0;
    if (enter_resp_c & acc_rd_c & ~fault_c) begin
      rdata_d = mem_q[acc_addr_c[IDX_W+1:2]];
    end
  end

  // State, counter, latched request and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= enter_resp_c;
      err_q   <= enter_resp_c & fault_c;
      rdata_q <= rdata_d;
      unique case (state_q)
        S_IDLE: begin
          if (req_c) begin
            addr_q  <= bus.Address;
            wdata_q <= bus.WriteData;
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (do_write_c) begin
      mem_q[acc_addr_c[IDX_W+1:2]] <= acc_wdata_c;
    end
  end

  // Stall is combinational so the CPU freezes in the very cycle it asks.
  assign bus.busy     = ((state_q == S_IDLE) & req_c) | (state_q == S_WAIT);
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.ReadData = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Purpose : Randomized and directed checking of data_memory_responder against
//           a transaction-level model, for WAIT_CYCLES=2 (index 0) and 0 (index 1).
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WA    = 2;
  localparam int unsigned WB    = 0;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        bsy   [2];
  logic        er    [2];

  bit [31:0] mdl [2][DEPTH];
  int        n_cmp = 0;
  int        n_err = 0;

  always #5 clk = ~clk;

  data_memory_responder_if bus_a ();
  data_memory_responder_if bus_b ();

  assign bus_a.MemRead   = rd[0];
  assign bus_a.MemWrite  = wr[0];
  assign bus_a.Address   = addr[0];
  assign bus_a.WriteData = wdat[0];
  assign rdata[0]        = bus_a.ReadData;
  assign rdy[0]          = bus_a.ready;
  assign bsy[0]          = bus_a.busy;
  assign er[0]           = bus_a.err;

  assign bus_b.MemRead   = rd[1];
  assign bus_b.MemWrite  = wr[1];
  assign bus_b.Address   = addr[1];
  assign bus_b.WriteData = wdat[1];
  assign rdata[1]        = bus_b.ReadData;
  assign rdy[1]          = bus_b.ready;
  assign bsy[1]          = bus_b.busy;
  assign er[1]           = bus_b.err;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_dut_a (
    .clock (clk),
    .reset (rst[0]),
    .bus   (bus_a)
  );

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)) u_dut_b (
    .clock (clk),
    .reset (rst[1]),
    .bus   (bus_b)
  );

  function automatic int wc(input int d);
    return (d == 0) ? int'(WA) : int'(WB);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One complete access: busy for W+1 cycles, then a single ready cycle.
  task automatic access(input int d, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    bit          fault;
    int unsigned idx;
    logic [31:0] exp_rd;
    int          lat;
    idx    = 32'(a[31:2]);
    fault  = (a[1:0] != 2'b00) || (idx >= DEPTH) || (r && w);
    exp_rd = 32'h0;
    if (r && !fault) exp_rd = mdl[d][idx];
    rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd;
    lat = -1;
    for (int k = 0; k < wc(d) + 4; k++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        lat = k;
        break;
      end
      chk("busy_during_access", 32'(bsy[d]), 32'd1);
      @(posedge clk); #1;
    end
    chk("ready_latency", 32'(lat), 32'(wc(d) + 1));
    if (lat >= 0) begin
      chk("busy_in_resp", 32'(bsy[d]), 32'd0);
      chk("err_in_resp", 32'(er[d]), 32'(fault));
      chk("rdata_in_resp", rdata[d], exp_rd);
    end
    if (w && !fault) mdl[d][idx] = wd;
    if (!hold) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Quiet IDLE cycle: everything low.
  task automatic idle_chk(input int d);
    @(negedge clk);
    chk("idle_busy", 32'(bsy[d]), 32'd0);
    chk("idle_ready", 32'(rdy[d]), 32'd0);
    chk("idle_err", 32'(er[d]), 32'd0);
    chk("idle_rdata", rdata[d], 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    idle_chk(0);
    idle_chk(1);

    // Give every word the tests will touch a known value.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
      access(d, 1'b0, 1'b1, 32'h3FC, $urandom, 1'b0);
    end

    // Write then read back, both wait-state settings.
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      idle_chk(d);
      access(d, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    end
    chk("word4_model", mdl[0][4], 32'hDEADBEEF);

    // Fault cases: misaligned, out of range, read+write together.
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
    access(0, 1'b1, 1'b1, 32'h10, 32'h55555555, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset during WAIT aborts a pending write.
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'h12345678;
    @(posedge clk); #1;
    rst[0] = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) idle_chk(0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // A request presented under reset is not latched.
    rst[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h24; wdat[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rst[0] = 1'b0; wr[0] = 1'b0;
    for (int i = 0; i < 4; i++) idle_chk(0);
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);

    // Back-to-back accesses with the request held across ready.
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 1'b1, 32'h30, 32'h11112222, 1'b1);
      access(d, 1'b0, 1'b1, 32'h34, 32'h33334444, 1'b1);
      access(d, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
      idle_chk(d);
    end

    // Random mix of legal and faulting accesses.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        int unsigned kind;
        int unsigned op;
        logic [31:0] a;
        bit r, w, h;
        kind = $urandom_range(0, 9);
        if (kind <= 6)      a = 32'($urandom_range(0, 15) * 4);
        else if (kind == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (kind == 8) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else                a = 32'h3FC;
        op = $urandom_range(0, 9);
        r  = (op < 5) || (op == 9);
        w  = (op >= 5);
        h  = ($urandom_range(0, 3) == 0) && (n != 79);
        access(d, r, w, a, $urandom, h);
      end
      idle_chk(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
